mult_arb_2: RTL and testbench
=============================

MULT_ARB_2 -- requirements
Module: mult_arb_2

Interface
REQ-001 Parameter LAT, default 1: fixed cycle count from mul_en high to the valid product on mul_out; legal range 1..8.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-004 req0 / req1  input  1 each  requester n presents an operand pair this cycle.
REQ-005 a0, b0 / a1, b1  input  16 each  operand pairs for requester 0 and requester 1.
REQ-006 gnt0 / gnt1  output  1 each  combinational; requester n's operands are accepted this cycle.
REQ-007 rsp_valid0 / rsp_valid1  output  1 each  registered one-cycle result pulse to requester n.
REQ-008 rsp_data0 / rsp_data1  output  16 each  result for requester n; valid only while its rsp_valid is high.
REQ-009 mul_a, mul_b  output  16 each  operands driven to the shared 16x16 multiplier.
REQ-010 mul_en  output  1  multiplier issue strobe, one cycle per accepted operation.
REQ-011 mul_out  input  16  multiplier product, low 16 bits, valid exactly LAT cycles after mul_en.
REQ-012 busy  output  1  high while any issued operation has not yet been returned.

Function
REQ-013 At most one grant per cycle; gnt0 & gnt1 shall never both be high.
REQ-014 Only one requester active -> that requester is granted in the same cycle.
REQ-015 Both requesting -> grant goes to the requester indicated by the 1-bit round-robin pointer rr (0 -> req0, 1 -> req1).
REQ-016 rr updates only on a grant: it becomes the index of the requester that was not granted. With no grant, rr holds.
REQ-017 The multiplier is fully pipelined, so a new grant is allowed every cycle with no stall or backpressure.
REQ-018 On a grant, mul_en=1 and mul_a/mul_b = the granted operands in the same cycle (combinational mux).
REQ-019 Without a grant, mul_en=0 and mul_a = mul_b = 16'd0.
REQ-020 A LAT-deep tag shift register carries {valid, requester id} alongside each issue.
REQ-021 When the tag exits the shift register, mul_out is registered into rsp_data of the tagged requester, and that requester's rsp_valid pulses in the following cycle.
REQ-022 Total latency from grant to rsp_valid is LAT+1 cycles.
REQ-023 Results return in issue order; product width is truncated to 16 bits (mod 2^16).
REQ-024 An outstanding counter (4 bits) increments on issue and decrements on the rsp_valid pulse; simultaneous issue and return leaves it unchanged.
REQ-025 busy = (counter != 0).
REQ-026 A requester that holds req high after a grant is treated as a new request in the next cycle.
REQ-027 rsp_data for the non-selected requester holds its previous value.

Reset
REQ-028 rst_n low at a rising edge:
  - rr <= 0
  - tag valids cleared
  - counter <= 0
  - rsp_valid0/1 <= 0
  - rsp_data0/1 <= 16'd0
REQ-029 Reset issued mid-operation discards all in-flight operations: no rsp_valid pulse shall occur for any operation issued before reset.
REQ-030 While rst_n is low, gnt0/gnt1/mul_en are forced to 0.

Verification
REQ-031 The bench models the multiplier as a LAT-stage registered 16x16 multiplier, and runs every scenario with LAT=1 and LAT=3.
REQ-032 Single op: req0, a0=2, b0=3 for one cycle -> gnt0=1, mul_en=1; rsp_valid0=1 with rsp_data0=6 exactly LAT+1 cycles later; rsp_valid1 stays 0.
REQ-033 Contention: req0 and req1 held high 4 cycles, a0=2 b0=3, a1=4 b1=5, after reset -> grants alternate 0,1,0,1; responses alternate 6,20,6,20 on the matching ports.
REQ-034 Back-to-back: req1 held 5 cycles with b1=3 and a1=1..5 -> five consecutive rsp_valid1 pulses with data 3,6,9,12,15; busy is high throughout and low the cycle after the last pulse.
REQ-035 Wrap: a0=16'h0100, b0=16'h0100 -> rsp_data0=16'h0000; a0=16'hFFFF, b0=2 -> rsp_data0=16'hFFFE.
REQ-036 Reset mid-flight (LAT=3): issue two ops, assert rst_n low one cycle later -> no rsp_valid ever occurs; busy=0 and rr=0 after reset; a subsequent req1 op 7*7 returns 49.

Source files
------------

// File: rtl/mult_arb_2.sv
// mult_arb_2: two-requester round-robin front end for one shared, fully
// pipelined 16x16 multiplier with a fixed latency of LAT cycles.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req0/a0/b0            requester 0 operand pair and request
//   req1/a1/b1            requester 1 operand pair and request
//   gnt0, gnt1            combinational same-cycle accept (one-hot or zero)
//   rsp_valid0/1          registered one-cycle result pulse per requester
//   rsp_data0/1           registered result, held between pulses
//   mul_a, mul_b, mul_en  issue port to the shared multiplier
//   mul_out               multiplier product, valid LAT cycles after mul_en
//   busy                  at least one issued operation not yet returned
module mult_arb_2 #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic [15:0] rsp_data0,
  output logic [15:0] rsp_data1,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [15:0] mul_out,
  output logic        busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  // Round-robin pointer: which requester wins when both ask.
  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_t;

  pri_t          pri_q;
  pri_t          pri_d;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ret;

  // Arbitration, issue mux and pointer next-state.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mul_a  = '0;
    mul_b  = '0;
    mul_en = 1'b0;
    pri_d  = pri_q;
    if (rst_n) begin
      if (req0 && (!req1 || (pri_q == PRI_REQ0))) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    // The loser of this cycle's grant gets priority next time.
    if (gnt0) begin
      mul_a  = a0;
      mul_b  = b0;
      mul_en = 1'b1;
      pri_d  = PRI_REQ1;
    end else if (gnt1) begin
      mul_a  = a1;
      mul_b  = b1;
      mul_en = 1'b1;
      pri_d  = PRI_REQ0;
    end
  end

  // Pointer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_q <= PRI_REQ0;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Tag pipeline tracking {valid, requester} in lockstep with the multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= mul_en;
      tag_id[0] <= gnt1;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Capture the product for the tagged requester; the other one holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data0  <= '0;
      rsp_data1  <= '0;
    end else begin
      rsp_valid0 <= tag_v[LAT-1] & ~tag_id[LAT-1];
      rsp_valid1 <= tag_v[LAT-1] &  tag_id[LAT-1];
      if (tag_v[LAT-1]) begin
        if (tag_id[LAT-1]) begin
          rsp_data1 <= DW'(mul_out);
        end else begin
          rsp_data0 <= DW'(mul_out);
        end
      end
    end
  end

  // Outstanding count: returns are counted on the registered pulse.
  assign ret = rsp_valid0 | rsp_valid1;

  always_comb begin
    cnt_d = cnt_q;
    case ({mul_en, ret})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_mult_arb_2.sv
// tb_mult_arb_2: scoreboard bench for mult_arb_2, one instance with LAT=1
// and one with LAT=3, each driven by the same directed scenario list.
module tb_mult_arb_2;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int unsigned L     = (gi == 0) ? 1 : 3;
    localparam int unsigned N_MID = (L >= 2) ? 2 : 1;

    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, mul_en, busy;
    logic [15:0] rsp_data0, rsp_data1, mul_a, mul_b, mul_out;
    logic [15:0] pipe [L];
    int unsigned cyc = 0;
    exp_t        sb [$];
    string       pfx;

    mult_arb_2 #(.LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
      .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
      .mul_out(mul_out), .busy(busy)
    );

    // LAT-stage registered multiplier, low 16 bits of the product.
    always @(posedge clk) begin
      pipe[0] <= 16'(mul_a * mul_b);
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
    assign mul_out = pipe[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare whenever a response is presented.
    always @(negedge clk) begin
      exp_t e;
      if (rsp_valid0 || rsp_valid1) begin
        if (sb.size() == 0) begin
          chk({pfx, "unexpected_rsp"}, {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({pfx, "rsp_port"}, {30'd0, rsp_valid1, rsp_valid0}, e.port ? 32'd2 : 32'd1);
          chk({pfx, "rsp_data"}, {16'd0, e.port ? rsp_data1 : rsp_data0}, {16'd0, e.data});
          chk({pfx, "rsp_cycle"}, cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk({pfx, "missing_rsp"}, {30'd0, rsp_valid1, rsp_valid0}, e.port ? 32'd2 : 32'd1);
      end
    end

    // One cycle: drive after the edge, check the combinational issue side mid-cycle.
    task automatic step(input logic rst, input logic r0, input logic [15:0] x0, y0,
                        input logic r1, input logic [15:0] x1, y1,
                        input logic [1:0] eg, input logic [15:0] ed, input bit keep);
      logic [15:0] ea, eb;
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst; req0 = r0; a0 = x0; b0 = y0; req1 = r1; a1 = x1; b1 = y1;
      @(negedge clk);
      ea = eg[0] ? x0 : (eg[1] ? x1 : 16'd0);
      eb = eg[0] ? y0 : (eg[1] ? y1 : 16'd0);
      chk({pfx, "grant"}, {30'd0, gnt1, gnt0}, {30'd0, eg});
      chk({pfx, "mul_en"}, {31'd0, mul_en}, {31'd0, |eg});
      chk({pfx, "mul_ab"}, {mul_a, mul_b}, {ea, eb});
      if (eg != 2'b00 && keep) begin
        e.port = eg[1];
        e.data = ed;
        e.due  = cyc + L + 1;
        sb.push_back(e);
      end
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 2'b00, 16'd0, 1'b0);
    endtask

    initial begin
      logic [15:0] b2b [5];
      b2b = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15};
      pfx = $sformatf("L%0d_", L);

      // Reset: requests present but nothing may be granted.
      step(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, 2'b00, 16'd0, 1'b0);
      chk({pfx, "rst_valid"}, {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
      chk({pfx, "rst_data"}, {rsp_data1, rsp_data0}, 32'd0);
      chk({pfx, "rst_busy"}, {31'd0, busy}, 32'd0);
      step(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, 2'b00, 16'd0, 1'b0);

      // Single op 2*3.
      step(1'b1, 1'b1, 16'd2, 16'd3, 1'b0, 16'd0, 16'd0, 2'b01, 16'd6, 1'b1);
      chk({pfx, "busy_idle_pre"}, {31'd0, busy}, 32'd0);
      idle(L + 3);

      // Contention from a fresh reset: 0,1,0,1.
      step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 2'b00, 16'd0, 1'b0);
      step(1'b1, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, 2'b01, 16'd6,  1'b1);
      step(1'b1, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, 2'b10, 16'd20, 1'b1);
      step(1'b1, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, 2'b01, 16'd6,  1'b1);
      step(1'b1, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, 2'b10, 16'd20, 1'b1);
      idle(L + 3);

      // Back-to-back on requester 1, busy profile around the last pulse.
      for (int i = 1; i <= 5; i++) begin
        step(1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 16'(i), 16'd3, 2'b10, b2b[i-1], 1'b1);
        if (i >= 2) chk({pfx, "busy_b2b"}, {31'd0, busy}, 32'd1);
      end
      for (int j = 1; j <= int'(L) + 2; j++) begin
        idle(1);
        chk({pfx, "busy_tail"}, {31'd0, busy}, (j <= int'(L) + 1) ? 32'd1 : 32'd0);
      end

      // Truncation to 16 bits.
      step(1'b1, 1'b1, 16'h0100, 16'h0100, 1'b0, 16'd0, 16'd0, 2'b01, 16'h0000, 1'b1);
      step(1'b1, 1'b1, 16'hFFFF, 16'd2,    1'b0, 16'd0, 16'd0, 2'b01, 16'hFFFE, 1'b1);
      idle(L + 3);

      // Reset mid-flight: issued ops must never return; pointer back to req0.
      for (int i = 0; i < int'(N_MID); i++)
        step(1'b1, 1'b1, 16'(3 + 2 * i), 16'(3 + 2 * i), 1'b0, 16'd0, 16'd0, 2'b01, 16'd0, 1'b0);
      step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 2'b00, 16'd0, 1'b0);
      step(1'b1, 1'b1, 16'd1, 16'd1, 1'b1, 16'd7, 16'd7, 2'b01, 16'd1, 1'b1);
      chk({pfx, "mid_busy"}, {31'd0, busy}, 32'd0);
      chk({pfx, "mid_data0"}, {16'd0, rsp_data0}, 32'd0);
      step(1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 16'd7, 16'd7, 2'b10, 16'd49, 1'b1);
      idle(L + 4);
      chk({pfx, "pending"}, sb.size(), 32'd0);
      chk({pfx, "end_busy"}, {31'd0, busy}, 32'd0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    chk("timeout", {30'd0, done[1], done[0]}, 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
